// File: rtl/flop_pipe.sv
// flop_pipe: DEPTH-stage elastic register pipeline with bubble-collapsing
// backpressure, synchronous flush and a registered occupancy count.
`timescale 1ns/1ps
module flop_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] stage_src [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic             head_room;
  logic             accept;
  logic [OW-1:0]    count_d;

  // Walk from the output back to stage 0; "room" means the stage ahead is
  // empty or is itself moving on this edge, so bubbles collapse in one cycle.
  always_comb begin
    logic room;
    logic a;
    adv  = '0;
    room = out_ready;
    a    = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      a      = valid_q[i] & room;
      adv[i] = a;
      room   = ~valid_q[i] | a;
    end
    head_room = room;
  end

  assign in_ready = ~flush & head_room;
  assign accept   = in_valid & in_ready;

  always_comb begin
    stage_src[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      stage_src[i] = data_q[i-1];
    end
  end

  // Flush wins over everything: no loads, every valid bit drops.
  always_comb begin
    valid_d = valid_q;
    load    = '0;
    if (flush) begin
      valid_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i]) valid_d[i] = 1'b0;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i-1]) begin
          valid_d[i] = 1'b1;
          load[i]    = 1'b1;
        end
      end
      if (accept) begin
        valid_d[0] = 1'b1;
        load[0]    = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + OW'(valid_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      occupancy <= '0;
    end else begin
      valid_q   <= valid_d;
      occupancy <= count_d;
    end
  end

  // Data registers only move when loaded; valid bits alone carry meaning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (load[i]) data_q[i] <= stage_src[i];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule
